pht_ctrl: RTL
=============

// Module: pht_ctrl
// PURPOSE
//  Owns the write port and index generation of the 2-bit-counter Pattern History Table (gshare).
//  Builds the fetch index from PC and global history, and computes saturating counter updates from EX outcomes.
//  Runs a one-entry-per-cycle initialisation sweep after reset or flush, replacing a 1024-wide reset fan-out.
//  Sits between IF/EX pipeline signals and a PHT storage array: 1 async read port (F), 1 sync write port.
// PARAMETERS
//  IDX_W     10     PHT index width; DEPTH = 2**IDX_W entries
//  GHR_W     10     global history length, GHR_W <= IDX_W
//  INIT_CNT  2'b01  counter value written by the sweep (weak not-taken)
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  flush_req    in   1      pulse: restart init sweep and clear GHR
//  pcF          in   32     fetch PC
//  pht_cntF     in   2      PHT read data at pht_indexF (async)
//  BranchE      in   1      EX stage holds a resolved conditional branch
//  br_actualE   in   1      actual outcome of that branch
//  pht_indexE   in   IDX_W  index used at fetch, piped down to EX by the datapath
//  pht_cntE     in   2      counter value captured at fetch, piped down to EX
//  pht_indexF   out  IDX_W  read index = pcF[IDX_W+1:2] ^ {{(IDX_W-GHR_W){1'b0}}, ghr}
//  pht_taken    out  1      prediction = pht_cntF[1] & ~busy
//  pht_we       out  1      PHT write enable
//  pht_waddr    out  IDX_W  PHT write address
//  pht_wdata    out  2      PHT write data
//  ghr          out  GHR_W  global history, LSB = newest outcome
//  busy         out  1      high while the sweep is active
//  drop_cnt     out  16     EX updates discarded during sweeps; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset values:
//   - state = SWEEP, sweep_ptr = 0, ghr = 0, drop_cnt = 0, busy = 1
//   - pht_we = 1, pht_waddr = 0, pht_wdata = INIT_CNT (registered outputs)
//  FSM has two states, SWEEP and RUN.
//  SWEEP:
//   - Each cycle issues pht_we = 1, waddr = sweep_ptr, wdata = INIT_CNT, then increments sweep_ptr.
//   - Write to DEPTH-1 -> next state RUN; sweep_ptr wraps to 0. Total sweep = exactly DEPTH cycles of writes.
//   - BranchE = 1 -> update dropped, drop_cnt += 1; ghr not shifted.
//   - pht_taken forced 0.
//  RUN:
//   - BranchE = 1 -> registered write next cycle: we = 1, waddr = pht_indexE, wdata = sat(pht_cntE, br_actualE).
//   - BranchE = 1 -> ghr <= {ghr[GHR_W-2:0], br_actualE} on the same edge.
//   - BranchE = 0 -> pht_we = 0 next cycle; waddr/wdata hold their previous values.
//  sat(c, t):
//   - t = 1 -> min(c+1, 3); t = 0 -> max(c-1, 0).
//   - 2-bit unsigned; never wraps 3->0 or 0->3.
//  Write latency: 1 cycle from BranchE to pht_we.
//   - A fetch read of the same index in that cycle sees the old value. The bypass is owned by the datapath.
//  flush_req:
//   - In any state -> next cycle state = SWEEP, sweep_ptr = 0, ghr = 0.
//   - A mid-sweep flush restarts the sweep from 0.
//   - An EX update in the same cycle as flush_req is dropped and counted.
//  reset dominates flush_req and all other inputs.
//  Back-to-back BranchE in RUN -> one write per cycle, in order, no stall. The controller never backpressures EX.
//  busy is combinational from state (SWEEP -> 1) and deasserts in the first RUN cycle.
//  pht_indexF is purely combinational from pcF and the registered ghr.
// STRUCTURE
//  bp_pkg holds:
//   - typedef enum logic [1:0] {SNT, WNT, WT, ST} cnt_t
//   - typedef enum logic {SWEEP, RUN} pht_state_t
//   - localparam cnt_t PHT_INIT = WNT
//   - function sat2(cnt_t c, logic t)
//  Single module, no sub-modules: FSM + sweep counter + GHR shift register + write-port mux + drop counter.
//  Storage array stays a separate module with a plain (we, waddr, wdata) write port.
// TESTING
//  1. Reset 1 cycle then release:
//     - pht_we = 1 for exactly 1024 cycles, waddr 0..1023, wdata = 2'b01, busy = 1, pht_taken = 0.
//     - Then busy = 0.
//  2. RUN, BranchE = 1, br_actualE = 1, pht_indexE = 10'h05A, pht_cntE = 2'b11:
//     - Next cycle we = 1, waddr = 10'h05A, wdata = 2'b11 (saturate).
//     - With pht_cntE = 2'b00, br_actualE = 0 -> wdata = 2'b00.
//  3. RUN, ghr = 0, outcomes 1,0,1,1 on four consecutive BranchE:
//     - ghr = 10'b1011.
//     - pcF = 32'h0000_0100 -> pht_indexF = 10'h040 ^ 10'h00B = 10'h04B.
//  4. Mid-sweep flush: flush_req at sweep_ptr = 500:
//     - Next write waddr = 0, ghr = 0.
//     - 1024 further sweep writes before busy = 0.
//  5. BranchE = 1 on 3 cycles during SWEEP, including one with flush_req:
//     - drop_cnt = 3, no non-INIT writes issued, ghr stays 0.
//  6. flush_req and reset asserted together in RUN:
//     - Reset values exactly.
//     - drop_cnt = 0 even if BranchE = 1.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the gshare branch predictor: 2-bit counter encoding, PHT controller
// states and the saturating counter update.
package bp_pkg;

  typedef enum logic [1:0] {SNT, WNT, WT, ST} cnt_t;

  typedef enum logic {SWEEP, RUN} pht_state_t;

  localparam cnt_t PHT_INIT = WNT;

  // Saturating 2-bit update: never wraps between ST and SNT.
  function automatic cnt_t sat2(cnt_t c, logic t);
    cnt_t r;
    r = c;
    if (t) begin
      if (c != ST) r = cnt_t'(c + 2'd1);
    end else begin
      if (c != SNT) r = cnt_t'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pht_ctrl.sv
// Gshare PHT controller: fetch index generation, registered counter write port, global
// history, and a one-entry-per-cycle init sweep after reset or flush.
module pht_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = 10,
  parameter int unsigned GHR_W    = 10,
  parameter logic [1:0]  INIT_CNT = PHT_INIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_req,
  input  logic [31:0]      pcF,
  input  logic [1:0]       pht_cntF,
  input  logic             BranchE,
  input  logic             br_actualE,
  input  logic [IDX_W-1:0] pht_indexE,
  input  logic [1:0]       pht_cntE,
  output logic [IDX_W-1:0] pht_indexF,
  output logic             pht_taken,
  output logic             pht_we,
  output logic [IDX_W-1:0] pht_waddr,
  output logic [1:0]       pht_wdata,
  output logic [GHR_W-1:0] ghr,
  output logic             busy,
  output logic [15:0]      drop_cnt
);

  pht_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [15:0]      drop_q, drop_d;
  logic             we_q, we_d;
  logic [IDX_W-1:0] waddr_q, waddr_d;
  logic [1:0]       wdata_q, wdata_d;
  logic [IDX_W-1:0] ghr_ext;
  logic             unused_pc;

  assign ghr_ext    = IDX_W'(ghr_q);
  assign pht_indexF = pcF[IDX_W+1:2] ^ ghr_ext;
  assign busy       = (state_q == SWEEP);
  assign pht_taken  = pht_cntF[1] & ~busy;
  assign pht_we     = we_q;
  assign pht_waddr  = waddr_q;
  assign pht_wdata  = wdata_q;
  assign ghr        = ghr_q;
  assign drop_cnt   = drop_q;
  assign unused_pc  = ^{pcF[31:IDX_W+2], pcF[1:0]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    drop_d  = drop_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    // An EX update that cannot reach the table is counted, never retried.
    if (BranchE && (state_q == SWEEP || flush_req) && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end

    if (flush_req) begin
      state_d = SWEEP;
      ptr_d   = '0;
      ghr_d   = '0;
      we_d    = 1'b1;
      waddr_d = '0;
      wdata_d = INIT_CNT;
    end else begin
      unique case (state_q)
        SWEEP: begin
          // Output registers always show the entry for the current ptr_q.
          ptr_d = ptr_q + IDX_W'(1);
          if (&ptr_q) begin
            state_d = RUN;
          end else begin
            we_d    = 1'b1;
            waddr_d = ptr_q + IDX_W'(1);
            wdata_d = INIT_CNT;
          end
        end
        RUN: begin
          if (BranchE) begin
            we_d    = 1'b1;
            waddr_d = pht_indexE;
            wdata_d = sat2(cnt_t'(pht_cntE), br_actualE);
            ghr_d   = {ghr_q[GHR_W-2:0], br_actualE};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
      ghr_q   <= '0;
      drop_q  <= '0;
      we_q    <= 1'b1;
      waddr_q <= '0;
      wdata_q <= INIT_CNT;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
